// File: rtl/pid_altitude_sequencer.sv
// Fixed-rate altitude loop sequencer: tick -> sample request -> pid_altitude hand-off -> clamped throttle,
// with miss counting, hover failsafe and sticky overrun detection.
module pid_altitude_sequencer #(
  parameter int unsigned       TICK_DIV    = 1000000,
  parameter int unsigned       TIMEOUT_CYC = 500000,
  parameter int unsigned       PID_TO_CYC  = 4,
  parameter int unsigned       MAX_MISSES  = 3,
  parameter logic signed [14:0] HOVER_P    = 15'sd8268,
  parameter logic signed [14:0] P_MAX      = 15'sd12240
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_cfg_valid,
  input  logic [7:0]         i_cfg_command,
  input  logic [7:0]         i_cfg_kp,
  output logic               o_meas_req,
  input  logic               i_meas_valid,
  input  logic signed [15:0] i_meas_data,
  output logic               o_pid_sink_data_valid,
  output logic signed [15:0] o_pid_sink_data,
  output logic [7:0]         o_pid_sink_command,
  output logic [7:0]         o_pid_sink_kp,
  input  logic               i_pid_source_valid,
  input  logic signed [14:0] i_pid_source_p,
  output logic               o_throttle_valid,
  output logic signed [14:0] o_throttle,
  output logic               o_failsafe,
  output logic               o_overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_TICK, S_REQ, S_WAIT_MEAS, S_FEED, S_WAIT_PID, S_MISS
  } state_t;

  state_t r_state, w_next;

  logic [31:0]        r_tick_cnt;
  logic [31:0]        r_to_cnt;
  logic               r_tick_pend;
  logic               r_overrun;
  logic [7:0]         r_stage_cmd, r_stage_kp;
  logic [7:0]         r_act_cmd, r_act_kp;
  logic signed [15:0] r_sink_data;
  logic [7:0]         r_sink_cmd, r_sink_kp;
  logic signed [14:0] r_throttle;
  logic               r_throttle_valid;
  logic               r_failsafe;
  logic [7:0]         r_miss_cnt;

  logic               w_tick;
  logic [7:0]         w_miss_inc;
  logic signed [14:0] w_clamped;

  assign w_tick     = i_enable && (r_state != S_IDLE) && (r_tick_cnt == TICK_DIV - 1);
  assign w_miss_inc = (r_miss_cnt < 8'(MAX_MISSES)) ? r_miss_cnt + 8'd1 : r_miss_cnt;

  always_comb begin
    w_clamped = i_pid_source_p;
    if (i_pid_source_p[14]) begin
      w_clamped = '0;
    end else if (i_pid_source_p > P_MAX) begin
      w_clamped = P_MAX;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Dropping enable aborts from any state on the very next edge.
  always_comb begin
    w_next = r_state;
    if (!i_enable) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:      w_next = S_WAIT_TICK;
        S_WAIT_TICK: if (w_tick || r_tick_pend) w_next = S_REQ;
        S_REQ:       w_next = S_WAIT_MEAS;
        S_WAIT_MEAS: begin
          if (i_meas_valid) w_next = S_FEED;
          else if (r_to_cnt == TIMEOUT_CYC - 1) w_next = S_MISS;
        end
        S_FEED:      w_next = S_WAIT_PID;
        S_WAIT_PID: begin
          if (i_pid_source_valid) w_next = S_WAIT_TICK;
          else if (r_to_cnt == PID_TO_CYC - 1) w_next = S_MISS;
        end
        S_MISS:      w_next = S_WAIT_TICK;
        default:     w_next = S_IDLE;
      endcase
    end
  end

  // A tick that lands while busy is remembered once; a second one is a lost tick.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tick_cnt  <= '0;
      r_tick_pend <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (!i_enable || r_state == S_IDLE) begin
      r_tick_cnt  <= '0;
      r_tick_pend <= 1'b0;
    end else begin
      r_tick_cnt <= (r_tick_cnt == TICK_DIV - 1) ? '0 : r_tick_cnt + 32'd1;
      if (r_state == S_WAIT_TICK) begin
        r_tick_pend <= 1'b0;
      end else if (w_tick) begin
        r_tick_pend <= 1'b1;
      end
      if (w_tick && r_tick_pend) begin
        r_overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_to_cnt <= '0;
    end else if (r_state == S_WAIT_MEAS || r_state == S_WAIT_PID) begin
      r_to_cnt <= r_to_cnt + 32'd1;
    end else begin
      r_to_cnt <= '0;
    end
  end

  // Sink values are frozen at capture so they stay stable from one FEED to the next.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_stage_cmd <= '0;
      r_stage_kp  <= '0;
      r_act_cmd   <= '0;
      r_act_kp    <= '0;
      r_sink_data <= '0;
      r_sink_cmd  <= '0;
      r_sink_kp   <= '0;
    end else begin
      if (i_cfg_valid) begin
        r_stage_cmd <= i_cfg_command;
        r_stage_kp  <= i_cfg_kp;
      end
      if (r_state == S_WAIT_TICK && w_next == S_REQ) begin
        r_act_cmd <= r_stage_cmd;
        r_act_kp  <= r_stage_kp;
      end
      if (r_state == S_WAIT_MEAS && w_next == S_FEED) begin
        r_sink_data <= i_meas_data;
        r_sink_cmd  <= r_act_cmd;
        r_sink_kp   <= r_act_kp;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_throttle       <= HOVER_P;
      r_throttle_valid <= 1'b0;
      r_failsafe       <= 1'b0;
      r_miss_cnt       <= '0;
    end else begin
      r_throttle_valid <= 1'b0;
      if (!i_enable) begin
        if (r_state != S_IDLE) begin
          r_throttle       <= HOVER_P;
          r_throttle_valid <= 1'b1;
        end
      end else if (r_state == S_WAIT_PID && i_pid_source_valid) begin
        r_throttle       <= w_clamped;
        r_throttle_valid <= 1'b1;
        r_miss_cnt       <= '0;
        r_failsafe       <= 1'b0;
      end else if (r_state == S_MISS) begin
        r_miss_cnt <= w_miss_inc;
        if (w_miss_inc == 8'(MAX_MISSES)) begin
          r_throttle       <= HOVER_P;
          r_throttle_valid <= 1'b1;
          r_failsafe       <= 1'b1;
        end
      end
    end
  end

  assign o_meas_req            = (r_state == S_REQ);
  assign o_pid_sink_data_valid = (r_state == S_FEED);
  assign o_pid_sink_data       = r_sink_data;
  assign o_pid_sink_command    = r_sink_cmd;
  assign o_pid_sink_kp         = r_sink_kp;
  assign o_throttle_valid      = r_throttle_valid;
  assign o_throttle            = r_throttle;
  assign o_failsafe            = r_failsafe;
  assign o_overrun             = r_overrun;

endmodule

// File: tb/tb_pid_altitude_sequencer.sv
// Directed bench for pid_altitude_sequencer: two instances share stimulus, one with a short sample
// timeout (loop, clamp, failsafe, cfg, disable) and one with a long timeout (pending tick, overrun).
module tb_pid_altitude_sequencer;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic               cfgValid;
  logic [7:0]         cfgCmd, cfgKp;
  logic               measValid;
  logic signed [15:0] measData;
  logic               pidValid;
  logic signed [14:0] pidP;

  logic               aReq, aSv, aTv, aFs, aOv;
  logic signed [15:0] aSd;
  logic [7:0]         aScmd, aSkp;
  logic signed [14:0] aThr;
  logic               bReq, bSv, bTv, bFs, bOv;
  logic signed [15:0] bSd;
  logic [7:0]         bScmd, bSkp;
  logic signed [14:0] bThr;

  bit                 useB = 1'b0;
  logic               mReq, mSv, mTv, mFs, mOv;
  logic signed [15:0] mSd;
  logic [7:0]         mScmd, mSkp;
  logic signed [14:0] mThr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pid_altitude_sequencer #(.TICK_DIV(100), .TIMEOUT_CYC(20), .PID_TO_CYC(4), .MAX_MISSES(3)) dutA (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_cfg_valid(cfgValid),
    .i_cfg_command(cfgCmd), .i_cfg_kp(cfgKp), .o_meas_req(aReq), .i_meas_valid(measValid),
    .i_meas_data(measData), .o_pid_sink_data_valid(aSv), .o_pid_sink_data(aSd),
    .o_pid_sink_command(aScmd), .o_pid_sink_kp(aSkp), .i_pid_source_valid(pidValid),
    .i_pid_source_p(pidP), .o_throttle_valid(aTv), .o_throttle(aThr), .o_failsafe(aFs),
    .o_overrun(aOv)
  );

  pid_altitude_sequencer #(.TICK_DIV(100), .TIMEOUT_CYC(200), .PID_TO_CYC(4), .MAX_MISSES(3)) dutB (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_cfg_valid(cfgValid),
    .i_cfg_command(cfgCmd), .i_cfg_kp(cfgKp), .o_meas_req(bReq), .i_meas_valid(measValid),
    .i_meas_data(measData), .o_pid_sink_data_valid(bSv), .o_pid_sink_data(bSd),
    .o_pid_sink_command(bScmd), .o_pid_sink_kp(bSkp), .i_pid_source_valid(pidValid),
    .i_pid_source_p(pidP), .o_throttle_valid(bTv), .o_throttle(bThr), .o_failsafe(bFs),
    .o_overrun(bOv)
  );

  assign mReq  = useB ? bReq  : aReq;
  assign mSv   = useB ? bSv   : aSv;
  assign mTv   = useB ? bTv   : aTv;
  assign mFs   = useB ? bFs   : aFs;
  assign mOv   = useB ? bOv   : aOv;
  assign mSd   = useB ? bSd   : aSd;
  assign mScmd = useB ? bScmd : aScmd;
  assign mSkp  = useB ? bSkp  : aSkp;
  assign mThr  = useB ? bThr  : aThr;

  task automatic doReset;
    reset = 1'b1; enable = 1'b0; cfgValid = 1'b0; cfgCmd = '0; cfgKp = '0;
    measValid = 1'b0; measData = '0; pidValid = 1'b0; pidP = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic loadCfg(input logic [7:0] cmd, input logic [7:0] kp);
    cfgValid = 1'b1; cfgCmd = cmd; cfgKp = kp;
    @(negedge clk);
    cfgValid = 1'b0;
  endtask

  // An expired wait counts as a failed comparison so a stuck DUT still reaches the summary.
  task automatic waitReq(input int maxCyc, output int waited);
    waited = 0;
    for (int i = 0; i < maxCyc; i++) begin
      @(negedge clk);
      if (mReq) begin
        waited = i + 1;
        break;
      end
    end
    total++;
    if (waited == 0) begin
      bad++;
      $display("[TB] FAIL waitReq: meas_req seen=0 within %0d cycles, required 1", maxCyc);
    end
  endtask

  // Called at the negedge where meas_req is high; answers after 'delay' cycles.
  task automatic serve(input int delay, input logic signed [15:0] data, input bit doPid,
                       input logic signed [14:0] p, output bit reqAfter, output bit sv,
                       output logic signed [15:0] sd, output logic [7:0] scmd,
                       output logic [7:0] skp, output bit tv, output logic signed [14:0] thr);
    @(negedge clk);
    reqAfter = mReq;
    repeat (delay - 1) @(negedge clk);
    measValid = 1'b1; measData = data;
    @(negedge clk);
    measValid = 1'b0;
    sv = mSv; sd = mSd; scmd = mScmd; skp = mSkp; tv = 1'b0; thr = mThr;
    if (doPid) begin
      @(negedge clk);
      pidValid = 1'b1; pidP = p;
      @(negedge clk);
      pidValid = 1'b0;
      tv = mTv; thr = mThr;
    end
  endtask

  task automatic test_reset;
    useB = 1'b0;
    doReset();
    total++; if (mThr !== 15'sd8268) begin bad++; $display("[TB] FAIL reset_throttle: got %0d, expected 8268", mThr); end
    total++; if (mTv !== 1'b0) begin bad++; $display("[TB] FAIL reset_tv: got %0b, expected 0", mTv); end
    total++; if (mReq !== 1'b0) begin bad++; $display("[TB] FAIL reset_req: got %0b, expected 0", mReq); end
    total++; if (mSv !== 1'b0) begin bad++; $display("[TB] FAIL reset_sink_valid: got %0b, expected 0", mSv); end
    total++; if (mFs !== 1'b0) begin bad++; $display("[TB] FAIL reset_failsafe: got %0b, expected 0", mFs); end
    total++; if (mOv !== 1'b0) begin bad++; $display("[TB] FAIL reset_overrun: got %0b, expected 0", mOv); end
  endtask

  task automatic test_basic;
    int w; bit ra, sv, tv; logic signed [15:0] sd; logic [7:0] sc, sk; logic signed [14:0] thr;
    useB = 1'b0;
    doReset();
    loadCfg(8'd100, 8'd16);
    enable = 1'b1;
    waitReq(150, w);
    total++; if (w != 101) begin bad++; $display("[TB] FAIL first_tick_latency: got %0d, expected 101", w); end
    serve(5, 16'sd1000, 1'b1, 15'sd600, ra, sv, sd, sc, sk, tv, thr);
    total++; if (ra !== 1'b0) begin bad++; $display("[TB] FAIL req_width: got %0b a cycle later, expected 0", ra); end
    total++; if (sv !== 1'b1) begin bad++; $display("[TB] FAIL sink_valid: got %0b, expected 1", sv); end
    total++; if (sd !== 16'sd1000) begin bad++; $display("[TB] FAIL sink_data: got %0d, expected 1000", sd); end
    total++; if (sc !== 8'd100) begin bad++; $display("[TB] FAIL sink_cmd: got %0d, expected 100", sc); end
    total++; if (sk !== 8'd16) begin bad++; $display("[TB] FAIL sink_kp: got %0d, expected 16", sk); end
    total++; if (tv !== 1'b1) begin bad++; $display("[TB] FAIL throttle_valid: got %0b, expected 1", tv); end
    total++; if (thr !== 15'sd600) begin bad++; $display("[TB] FAIL throttle_600: got %0d, expected 600", thr); end
  endtask

  task automatic test_clamp;
    int w; bit ra, sv, tv; logic signed [15:0] sd; logic [7:0] sc, sk; logic signed [14:0] thr;
    waitReq(150, w);
    serve(5, 16'sd2000, 1'b1, -15'sd50, ra, sv, sd, sc, sk, tv, thr);
    total++; if (tv !== 1'b1 || thr !== 15'sd0) begin bad++; $display("[TB] FAIL clamp_low: got tv=%0b thr=%0d, expected tv=1 thr=0", tv, thr); end
    waitReq(150, w);
    serve(5, 16'sd2100, 1'b1, 15'sd13000, ra, sv, sd, sc, sk, tv, thr);
    total++; if (tv !== 1'b1 || thr !== 15'sd12240) begin bad++; $display("[TB] FAIL clamp_high: got tv=%0b thr=%0d, expected tv=1 thr=12240", tv, thr); end
  endtask

  task automatic test_failsafe;
    int w; bit pulse; bit ra, sv, tv; logic signed [15:0] sd; logic [7:0] sc, sk; logic signed [14:0] thr;
    for (int m = 1; m <= 3; m++) begin
      waitReq(150, w);
      pulse = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (mTv) pulse = 1'b1;
      end
      if (m < 3) begin
        total++; if (pulse !== 1'b0 || mThr !== 15'sd12240 || mFs !== 1'b0) begin bad++; $display("[TB] FAIL miss_%0d: got pulse=%0b thr=%0d fs=%0b, expected 0/12240/0", m, pulse, mThr, mFs); end
      end else begin
        total++; if (pulse !== 1'b1 || mThr !== 15'sd8268 || mFs !== 1'b1) begin bad++; $display("[TB] FAIL miss_3: got pulse=%0b thr=%0d fs=%0b, expected 1/8268/1", pulse, mThr, mFs); end
      end
    end
    waitReq(150, w);
    serve(5, 16'sd1200, 1'b1, 15'sd900, ra, sv, sd, sc, sk, tv, thr);
    total++; if (mFs !== 1'b0 || thr !== 15'sd900) begin bad++; $display("[TB] FAIL failsafe_clear: got fs=%0b thr=%0d, expected 0/900", mFs, thr); end
  endtask

  task automatic test_overrun;
    int w; bit ra, sv, tv; logic signed [15:0] sd; logic [7:0] sc, sk; logic signed [14:0] thr;
    useB = 1'b1;
    doReset();
    enable = 1'b1;
    waitReq(150, w);
    serve(150, 16'sd3000, 1'b1, 15'sd400, ra, sv, sd, sc, sk, tv, thr);
    total++; if (mOv !== 1'b0) begin bad++; $display("[TB] FAIL overrun_early: got %0b, expected 0", mOv); end
    waitReq(5, w);
    total++; if (w != 1) begin bad++; $display("[TB] FAIL pend_req: got %0d cycles, expected 1", w); end
    serve(150, 16'sd3100, 1'b1, 15'sd450, ra, sv, sd, sc, sk, tv, thr);
    total++; if (mOv !== 1'b1) begin bad++; $display("[TB] FAIL overrun_set: got %0b, expected 1", mOv); end
    enable = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (mOv !== 1'b1) begin bad++; $display("[TB] FAIL overrun_sticky: got %0b, expected 1", mOv); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (mOv !== 1'b0) begin bad++; $display("[TB] FAIL overrun_reset: got %0b, expected 0", mOv); end
    useB = 1'b0;
  endtask

  task automatic test_async_reset;
    int w; bit ra, sv, tv; logic signed [15:0] sd; logic [7:0] sc, sk; logic signed [14:0] thr;
    useB = 1'b0;
    doReset();
    enable = 1'b1;
    waitReq(150, w);
    serve(5, 16'sd1000, 1'b1, 15'sd600, ra, sv, sd, sc, sk, tv, thr);
    waitReq(150, w);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++; if (mThr !== 15'sd8268 || mTv !== 1'b0 || mReq !== 1'b0 || mSv !== 1'b0 || mFs !== 1'b0 || mOv !== 1'b0) begin
      bad++; $display("[TB] FAIL async_reset: got thr=%0d tv=%0b req=%0b sv=%0b fs=%0b ov=%0b, expected 8268/0/0/0/0/0", mThr, mTv, mReq, mSv, mFs, mOv);
    end
    @(negedge clk);
    enable = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_cfg_and_disable;
    int w; bit ra, sv, tv; logic signed [15:0] sd; logic [7:0] sc, sk; logic signed [14:0] thr;
    useB = 1'b0;
    doReset();
    loadCfg(8'd100, 8'd16);
    enable = 1'b1;
    repeat (100) @(negedge clk);
    cfgValid = 1'b1; cfgCmd = 8'd100; cfgKp = 8'd32;
    @(negedge clk);
    cfgValid = 1'b0;
    total++; if (mReq !== 1'b1) begin bad++; $display("[TB] FAIL tick_edge_req: got %0b, expected 1", mReq); end
    serve(5, 16'sd1500, 1'b1, 15'sd700, ra, sv, sd, sc, sk, tv, thr);
    total++; if (sk !== 8'd16) begin bad++; $display("[TB] FAIL kp_old: got %0d, expected 16", sk); end
    waitReq(150, w);
    serve(5, 16'sd1600, 1'b0, 15'sd0, ra, sv, sd, sc, sk, tv, thr);
    total++; if (sk !== 8'd32) begin bad++; $display("[TB] FAIL kp_new: got %0d, expected 32", sk); end
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    total++; if (mTv !== 1'b1 || mThr !== 15'sd8268) begin bad++; $display("[TB] FAIL disable_pulse: got tv=%0b thr=%0d, expected 1/8268", mTv, mThr); end
    @(negedge clk);
    total++; if (mTv !== 1'b0 || mReq !== 1'b0) begin bad++; $display("[TB] FAIL disable_idle: got tv=%0b req=%0b, expected 0/0", mTv, mReq); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_failsafe();
    test_async_reset();
    test_cfg_and_disable();
    test_overrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
